serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor. It is the subtract-direction counterpart of the team's full adder cell. One full-subtractor cell and a borrow flip-flop process operands LSB-first, one bit per clock. Operands enter through a valid/ready start handshake, and the result leaves through a valid/ready done handshake. Used where area matters more than throughput, e.g. ALU datapaths with spare cycles.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset; asynchronous and active-low.
start_valid  input  1  operands a, b, bin valid.
start_ready  output  1  block idle, can accept operands.
a  input  WIDTH  minuend; sampled only at start handshake.
b  input  WIDTH  subtrahend; sampled only at start handshake.
bin  input  1  borrow-in; sampled only at start handshake.
diff  output  WIDTH  difference, registered.
bout  output  1  final borrow-out, registered.
done_valid  output  1  diff/bout valid.
done_ready  input  1  consumer accepts result.
busy  output  1  high in SHIFT state.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values while rst_n low: state=IDLE, diff=0, bout=0, done_valid=0, busy=0, start_ready=1, internal shift registers, borrow flop and bit counter all 0.
  - Handshakes are ignored while rst_n is low.
  - First accept is possible on the first rising edge after rst_n rises.
- FSM states: IDLE, SHIFT, DONE. Outputs are decoded from state:
  - start_ready = (state==IDLE)
  - busy = (state==SHIFT)
  - done_valid = (state==DONE)
- IDLE: when start_valid & start_ready at a rising edge:
  - load a_sr<=a, b_sr<=b, brw<=bin, cnt<=0;
  - go to SHIFT.
  - Otherwise hold.
- SHIFT, each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ brw
  - nb = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
  - a_sr, b_sr shift right one bit.
  - diff shifts right with d inserted at MSB, so after WIDTH shifts diff[0] holds bit 0.
  - brw <= nb; cnt <= cnt+1.
  - When cnt==WIDTH-1: bout <= nb, go to DONE.
  - SHIFT lasts exactly WIDTH cycles.
- Latency: start handshake at edge T gives done_valid high after edge T+WIDTH.
- diff contents during SHIFT are partial and undefined to the consumer; only valid when done_valid=1.
- DONE: diff and bout held stable while done_valid & ~done_ready. On done_valid & done_ready at an edge, go to IDLE.
  - diff/bout keep the last result until the next SHIFT begins.
  - start_ready rises the cycle after the result handshake; there is no same-cycle result-release plus new-accept.
- Arithmetic:
  - diff = (a - b - bin) mod 2^WIDTH
  - bout = 1 iff a < b + bin (unsigned)
  - Chaining bout into the next block's bin gives multiword subtract.
- start_valid during SHIFT/DONE is ignored, with no effect on state.
- a, b, bin changes after acceptance do not affect the result.
- WIDTH=1: SHIFT lasts one cycle, counter width max(1, clog2(WIDTH)).
- Reset asserted mid-SHIFT or in DONE: immediate asynchronous return to reset values. The in-flight result is discarded, not reported.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0. done_valid first high exactly 8 cycles after accept edge; busy high those 8 cycles.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
3. Backpressure: hold done_ready=0 for 5 cycles after done_valid; toggle start_valid with a=0x01, b=0x02 -> diff/bout unchanged, start_ready=0, no accept. Raise done_ready -> start_ready=1 next cycle, then new op gives diff=0xFF, bout=1.
4. Operand stability: accept a=0x80, b=0x01, bin=0, then drive a=0x00, b=0xFF during SHIFT -> diff=0x7F, bout=0.
5. Reset mid-operation: drop rst_n asynchronously (between edges) at 3rd SHIFT cycle -> diff=0, bout=0, done_valid=0, busy=0 immediately, start_ready=1. After release, a=0x03, b=0x05, bin=1 -> diff=0xFD, bout=1.
6. Exhaustive with WIDTH=4: all a, b, bin combinations back-to-back with done_ready=1 -> each diff/bout matches (a-b-bin) mod 16 / borrow. Each op takes 4 SHIFT + 1 DONE + 1 IDLE cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Operands enter on a start handshake; the result leaves on a done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] diff_shift;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             d_bit, nb_bit;

  // Full-subtractor cell on the current LSBs.
  assign d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
  assign nb_bit = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);

  // New bit enters at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
  if (WIDTH == 1) begin : g_shift_w1
    assign diff_shift = d_bit;
  end else begin : g_shift_wn
    assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = diff_shift;
        brw_d  = nb_bit;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          bout_d  = nb_bit;
          state_d = StDone;
        end
      end
      StDone: begin
        if (done_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q == StShift);
  assign done_valid  = (state_q == StDone);
  assign diff        = diff_q;
  assign bout        = bout_q;

endmodule
